// File: rtl/qbus_target.sv
// Bus responder for the vm1 SYNC/DIN/DOUT/WTBT/RPLY bus: decodes an address window,
// inserts programmable wait states and maps accesses onto a synchronous RAM port.
module qbus_target #(
  parameter logic [15:0] BASE        = 16'o100000,
  parameter int          AW          = 10,
  parameter int          WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          sync_i,
  input  logic          din_i,
  input  logic          dout_i,
  input  logic          wtbt_i,
  input  logic [15:0]   addr_i,
  input  logic [15:0]   data_i,
  output logic [15:0]   data_o,
  output logic          rply_o,
  output logic          sel_o,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic [1:0]    mem_we,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MISS  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RD    = 3'd3,
    ST_REPLY = 3'd4
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t        state_r;
  logic          sync_r;
  logic [3:0]    cnt_r;
  logic [AW:0]   addr_r;
  logic          wtbt_r;
  logic          rd_r;
  logic          rply_r;
  logic          sel_r;
  logic          mem_re_r;
  logic [1:0]    mem_we_r;
  logic [15:0]   mem_wdata_r;
  logic [15:0]   data_r;
  logic          start_s;
  logic          hit_s;

  function automatic logic [1:0] byte_we(input logic wtbt, input logic a0);
    logic [1:0] we;
    case ({wtbt, a0})
      2'b10:   we = 2'b01;
      2'b11:   we = 2'b10;
      default: we = 2'b11;
    endcase
    return we;
  endfunction

  assign start_s = sync_i & ~sync_r;
  assign hit_s   = (addr_i[15:AW+1] == BASE[15:AW+1]);

  // Bus cycle sequencer; every state change and output register is qualified by ce
  always_ff @(posedge clk) begin
    if (ce) begin
      if (!reset_n) begin
        state_r     <= ST_IDLE;
        sync_r      <= 1'b0;
        cnt_r       <= 4'd0;
        addr_r      <= '0;
        wtbt_r      <= 1'b0;
        rd_r        <= 1'b0;
        rply_r      <= 1'b0;
        sel_r       <= 1'b0;
        mem_re_r    <= 1'b0;
        mem_we_r    <= 2'b00;
        mem_wdata_r <= 16'h0000;
        data_r      <= 16'h0000;
      end else begin
        sync_r   <= sync_i;
        mem_re_r <= 1'b0;
        mem_we_r <= 2'b00;
        case (state_r)
          ST_IDLE: begin
            if (start_s && hit_s) begin
              addr_r  <= addr_i[AW:0];
              wtbt_r  <= wtbt_i;
              cnt_r   <= WS;
              rd_r    <= 1'b0;
              sel_r   <= 1'b1;
              state_r <= ST_WAIT;
            end else if (start_s) begin
              state_r <= ST_MISS;
            end
          end
          ST_MISS: begin
            if (!sync_i) state_r <= ST_IDLE;
          end
          ST_WAIT: begin
            if (!sync_i) begin
              sel_r   <= 1'b0;
              state_r <= ST_IDLE;
            end else if (cnt_r != 4'd0) begin
              cnt_r <= cnt_r - 4'd1;
            end else if (din_i) begin
              mem_re_r <= 1'b1;
              rd_r     <= 1'b1;
              state_r  <= ST_RD;
            end else if (dout_i) begin
              mem_we_r    <= byte_we(wtbt_r, addr_r[0]);
              mem_wdata_r <= data_i;
              state_r     <= ST_REPLY;
            end
          end
          ST_RD: begin
            if (!sync_i) begin
              sel_r   <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_REPLY;
            end
          end
          ST_REPLY: begin
            if (!sync_i || (!din_i && !dout_i)) begin
              rply_r  <= 1'b0;
              sel_r   <= 1'b0;
              data_r  <= 16'h0000;
              state_r <= ST_IDLE;
            end else begin
              // RAM data arrives the cycle after the strobe, so it is taken as RPLY rises
              if (rd_r && !rply_r) data_r <= mem_rdata;
              rply_r <= 1'b1;
            end
          end
          default: begin
            rply_r  <= 1'b0;
            sel_r   <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign rply_o    = rply_r;
  assign sel_o     = sel_r;
  assign mem_addr  = addr_r[AW:1];
  assign mem_re    = mem_re_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mem_wdata_r;
  assign data_o    = (rply_r && din_i) ? data_r : 16'h0000;

endmodule

// File: tb/tb_qbus_target.sv
// Scoreboard bench for qbus_target: two instances (0 and 3 wait states) with RAM models.
module tb_qbus_target;

  logic        clk = 1'b0;
  logic        reset_n, ce;
  logic        sync_ws0, sync_ws3;
  logic        din_i, dout_i, wtbt_i;
  logic [15:0] addr_i, data_i;

  logic        rply0, sel0, mem_re0, rply3, sel3, mem_re3;
  logic [15:0] data0, data3, mem_wdata0, mem_wdata3, mem_rdata0, mem_rdata3;
  logic [9:0]  mem_addr0, mem_addr3;
  logic [1:0]  mem_we0, mem_we3;

  logic [1:0]       rply_s, sel_s;
  logic [1:0][15:0] data_s, wdata_s;
  logic [1:0][9:0]  maddr_s;
  logic [1:0][1:0]  we_s;

  logic [15:0] ram0 [0:1023];
  logic [15:0] ram3 [0:1023];
  logic [15:0] model [0:1][0:1023];
  logic [15:0] exp_q [$];

  int we_cnt [2];
  int re_cnt [2];
  int rply_cnt [2];
  int act_cnt [2];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  qbus_target #(.BASE(16'o100000), .AW(10), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .sync_i(sync_ws0), .din_i(din_i),
    .dout_i(dout_i), .wtbt_i(wtbt_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data0), .rply_o(rply0), .sel_o(sel0), .mem_addr(mem_addr0),
    .mem_re(mem_re0), .mem_we(mem_we0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0));

  qbus_target #(.BASE(16'o100000), .AW(10), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .sync_i(sync_ws3), .din_i(din_i),
    .dout_i(dout_i), .wtbt_i(wtbt_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data3), .rply_o(rply3), .sel_o(sel3), .mem_addr(mem_addr3),
    .mem_re(mem_re3), .mem_we(mem_we3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3));

  assign rply_s  = {rply3, rply0};
  assign sel_s   = {sel3, sel0};
  assign data_s  = {data3, data0};
  assign wdata_s = {mem_wdata3, mem_wdata0};
  assign maddr_s = {mem_addr3, mem_addr0};
  assign we_s    = {mem_we3, mem_we0};

  // Synchronous RAM models: byte writes, registered read one enabled cycle after mem_re
  always @(posedge clk) begin
    if (ce) begin
      if (mem_we0[0]) ram0[mem_addr0][7:0]  <= mem_wdata0[7:0];
      if (mem_we0[1]) ram0[mem_addr0][15:8] <= mem_wdata0[15:8];
      if (mem_re0)    mem_rdata0 <= ram0[mem_addr0];
      if (mem_we3[0]) ram3[mem_addr3][7:0]  <= mem_wdata3[7:0];
      if (mem_we3[1]) ram3[mem_addr3][15:8] <= mem_wdata3[15:8];
      if (mem_re3)    mem_rdata3 <= ram3[mem_addr3];
    end
  end

  // Activity counters sampled at each clock edge
  always @(posedge clk) begin
    if (ce && mem_we0 != 2'b00) we_cnt[0] <= we_cnt[0] + 1;
    if (ce && mem_we3 != 2'b00) we_cnt[1] <= we_cnt[1] + 1;
    if (ce && mem_re0) re_cnt[0] <= re_cnt[0] + 1;
    if (ce && mem_re3) re_cnt[1] <= re_cnt[1] + 1;
    if (rply0) rply_cnt[0] <= rply_cnt[0] + 1;
    if (rply3) rply_cnt[1] <= rply_cnt[1] + 1;
    if (rply0 || sel0 || mem_re0 || mem_we0 != 2'b00) act_cnt[0] <= act_cnt[0] + 1;
    if (rply3 || sel3 || mem_re3 || mem_we3 != 2'b00) act_cnt[1] <= act_cnt[1] + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_sync(input int d, input logic v);
    if (d == 0) sync_ws0 = v;
    else        sync_ws3 = v;
  endtask

  // Start a cycle, wait for RPLY, check latency and the write strobe or read data
  task automatic start_cyc(input int d, input logic wr, input logic [15:0] a,
                           input logic [15:0] wd, input logic bt, input int exp_lat);
    int          lat;
    logic [1:0]  we_seen, exp_we;
    logic [9:0]  wa_seen;
    logic [15:0] wd_seen, exp_rd;
    lat = -1; we_seen = 2'b00; wa_seen = 10'd0; wd_seen = 16'h0000;
    exp_we = !bt ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
    @(negedge clk);
    addr_i = a; data_i = wd; wtbt_i = bt; din_i = !wr; dout_i = wr;
    set_sync(d, 1'b1);
    if (wr) begin
      if (!bt)      model[d][a[10:1]]       = wd;
      else if (a[0]) model[d][a[10:1]][15:8] = wd[15:8];
      else          model[d][a[10:1]][7:0]  = wd[7:0];
    end else begin
      exp_q.push_back(model[d][a[10:1]]);
    end
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (we_s[d] != 2'b00 && we_seen == 2'b00) begin
        we_seen = we_s[d]; wa_seen = maddr_s[d]; wd_seen = wdata_s[d];
      end
      if (rply_s[d]) begin
        lat = n;
        break;
      end
    end
    check($sformatf("latency_d%0d", d), lat, exp_lat);
    if (wr) begin
      check("mem_we", {30'd0, we_seen}, {30'd0, exp_we});
      check("mem_addr", {22'd0, wa_seen}, {22'd0, a[10:1]});
      check("mem_wdata", {16'd0, wd_seen}, {16'd0, wd});
    end else if (exp_q.size() > 0) begin
      exp_rd = exp_q.pop_front();
      check("read_data", {16'd0, data_s[d]}, {16'd0, exp_rd});
    end
  endtask

  task automatic end_cyc(input int d);
    @(negedge clk); din_i = 1'b0; dout_i = 1'b0;
    @(posedge clk); #1;
    check("rply_release", {31'd0, rply_s[d]}, 32'd0);
    @(negedge clk); set_sync(d, 1'b0);
    @(posedge clk);
  endtask

  task automatic xfer(input int d, input logic wr, input logic [15:0] a,
                      input logic [15:0] wd, input logic bt, input int exp_lat);
    start_cyc(d, wr, a, wd, bt, exp_lat);
    end_cyc(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_a, snap_b;
    reset_n = 1'b0; ce = 1'b1; sync_ws0 = 1'b0; sync_ws3 = 1'b0;
    din_i = 1'b0; dout_i = 1'b0; wtbt_i = 1'b0; addr_i = 16'h0000; data_i = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rply", {30'd0, rply_s}, 32'd0);
    check("rst_sel", {30'd0, sel_s}, 32'd0);
    check("rst_strobes", {28'd0, mem_re0, mem_re3, we_s[0]}, 32'd0);
    check("rst_data", {data_s[1], data_s[0]}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk);

    // Word write then read back, no wait states
    xfer(0, 1'b1, 16'o100002, 16'o123456, 1'b0, 2);
    xfer(0, 1'b0, 16'o100002, 16'h0000, 1'b0, 3);

    // Byte lanes: odd byte then even byte into a known word
    xfer(0, 1'b1, 16'o100004, 16'h1234, 1'b0, 2);
    xfer(0, 1'b1, 16'o100005, 16'hA55A, 1'b1, 2);
    xfer(0, 1'b0, 16'o100004, 16'h0000, 1'b0, 3);
    xfer(0, 1'b1, 16'o100004, 16'hC33C, 1'b1, 2);
    xfer(0, 1'b0, 16'o100004, 16'h0000, 1'b0, 3);

    // Out-of-window access stays silent, next hit works
    snap_a = act_cnt[0];
    @(negedge clk); addr_i = 16'o040000; din_i = 1'b1; sync_ws0 = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); din_i = 1'b0; sync_ws0 = 1'b0;
    @(posedge clk); #1;
    check("miss_quiet", act_cnt[0] - snap_a, 32'd0);
    xfer(0, 1'b0, 16'o100002, 16'h0000, 1'b0, 3);

    // Three wait states: write, aborted read, repeated read
    xfer(1, 1'b1, 16'o100010, 16'hBEEF, 1'b0, 5);
    snap_a = re_cnt[1]; snap_b = rply_cnt[1];
    @(negedge clk); addr_i = 16'o100010; din_i = 1'b1; sync_ws3 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); sync_ws3 = 1'b0;
    @(posedge clk); #1;
    check("abort_sel", {31'd0, sel_s[1]}, 32'd0);
    @(negedge clk); din_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_re", re_cnt[1] - snap_a, 32'd0);
    check("abort_no_rply", rply_cnt[1] - snap_b, 32'd0);
    xfer(1, 1'b0, 16'o100010, 16'h0000, 1'b0, 6);

    // Reset while replying
    start_cyc(0, 1'b0, 16'o100002, 16'h0000, 1'b0, 3);
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_in_reply_rply", {31'd0, rply_s[0]}, 32'd0);
    check("rst_in_reply_data", {16'd0, data_s[0]}, 32'd0);
    @(negedge clk); reset_n = 1'b1; din_i = 1'b0; sync_ws0 = 1'b0;
    @(posedge clk);
    xfer(0, 1'b1, 16'o100006, 16'h7777, 1'b0, 2);
    xfer(0, 1'b0, 16'o100006, 16'h0000, 1'b0, 3);

    // dout held across many cycles with ce toggling: a single write pulse
    snap_a = we_cnt[0];
    start_cyc(0, 1'b1, 16'o100012, 16'h4242, 1'b0, 2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); ce = ~ce;
      @(posedge clk);
    end
    #1;
    check("rply_hold", {31'd0, rply_s[0]}, 32'd1);
    @(negedge clk); dout_i = 1'b0; ce = 1'b0;
    @(posedge clk); #1;
    check("rply_frozen", {31'd0, rply_s[0]}, 32'd1);
    @(negedge clk); ce = 1'b1;
    @(posedge clk); #1;
    check("rply_drop", {31'd0, rply_s[0]}, 32'd0);
    check("single_we", we_cnt[0] - snap_a, 32'd1);
    @(negedge clk); sync_ws0 = 1'b0;
    @(posedge clk);
    xfer(0, 1'b0, 16'o100012, 16'h0000, 1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
